// File: rtl/stage_sample_serializer_pkg.sv
// Shared types and constants for the I2S sample serializer.
// Slot width follows from the sample width.
package stage_sample_serializer_pkg;

  localparam int SAMPLE_WIDTH = 16;
  localparam int I2S_SLOTS = 2 * SAMPLE_WIDTH;
  localparam int BCLK_DIV_DEFAULT = 4;
  localparam int SLOT_W = $clog2(I2S_SLOTS);

  typedef logic signed [SAMPLE_WIDTH-1:0] Sample_t;
  typedef logic [SLOT_W-1:0] slot_t;

  typedef enum logic [1:0] {
    SRC_NEW,
    SRC_PEND,
    SRC_LAST
  } load_src_e;

endpackage

// File: rtl/stage_sample_serializer_if.sv
// Sample input strobe and I2S output bundle.
// master = upstream/observer, slave = serializer.
interface stage_sample_serializer_if;
  import stage_sample_serializer_pkg::*;

  Sample_t i_Sample;
  logic    i_SampleReady;
  logic    o_BitClock;
  logic    o_WordSelect;
  logic    o_SerialData;
  logic    o_FrameStart;
  logic    o_Underrun;
  logic    o_Overrun;

  modport master (
    output i_Sample,
    output i_SampleReady,
    input  o_BitClock,
    input  o_WordSelect,
    input  o_SerialData,
    input  o_FrameStart,
    input  o_Underrun,
    input  o_Overrun
  );

  modport slave (
    input  i_Sample,
    input  i_SampleReady,
    output o_BitClock,
    output o_WordSelect,
    output o_SerialData,
    output o_FrameStart,
    output o_Underrun,
    output o_Overrun
  );

endinterface

// File: rtl/stage_sample_serializer_i2s_clock_gen.sv
// BCLK divider and slot counter for the serializer.
// fall is high in the cycle whose edge drops BCLK.
module i2s_clock_gen
  import stage_sample_serializer_pkg::*;
#(
  parameter int BCLK_DIV = BCLK_DIV_DEFAULT
) (
  input  logic  i_Clock,
  input  logic  i_Reset_n,
  output logic  bit_clock,
  output slot_t slot,
  output logic  fall
);

  localparam int DIV_W =
    (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX =
    DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic wrap;

  assign wrap = (div == DIV_MAX);
  assign fall = wrap & bit_clock;

  // Half-period divider, wraps every BCLK_DIV clocks.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      div <= '0;
    end else if (wrap) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // BCLK toggles on every divider wrap.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      bit_clock <= 1'b0;
    end else if (wrap) begin
      bit_clock <= ~bit_clock;
    end
  end

  // Slot counter advances on each BCLK fall.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      slot <= '0;
    end else if (fall) begin
      slot <= slot + slot_t'(1);
    end
  end

endmodule

// File: rtl/stage_sample_serializer.sv
// Buffers one mono sample and sends it as an
// I2S stereo frame (same word left and right).
module stage_sample_serializer
  import stage_sample_serializer_pkg::*;
#(
  parameter int BCLK_DIV = BCLK_DIV_DEFAULT
) (
  input logic i_Clock,
  input logic i_Reset_n,
  stage_sample_serializer_if.slave bus
);

  localparam int FRAME_W = 2 * SAMPLE_WIDTH;
  localparam slot_t SLOT_LAST =
    slot_t'(I2S_SLOTS - 1);
  localparam slot_t SLOT_RIGHT =
    slot_t'(SAMPLE_WIDTH);

  logic bit_clock;
  logic fall;
  logic load;
  logic ws_q;
  logic sd_q;
  logic hold_q;
  logic pend_v;
  slot_t slot;
  slot_t next_slot;
  Sample_t pend_q;
  Sample_t last_q;
  Sample_t load_word;
  load_src_e src;
  logic [FRAME_W-1:0] shreg;

  i2s_clock_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_clock_gen (
    .i_Clock   (i_Clock),
    .i_Reset_n (i_Reset_n),
    .bit_clock (bit_clock),
    .slot      (slot),
    .fall      (fall)
  );

  assign next_slot = slot + slot_t'(1);
  assign load = fall & (slot == SLOT_LAST);

  // Pick the frame word: fresh strobe, then pending,
  // then repeat the last word.
  always_comb begin
    src = SRC_LAST;
    load_word = last_q;
    unique case (1'b1)
      bus.i_SampleReady: begin
        src = SRC_NEW;
        load_word = bus.i_Sample;
      end
      !bus.i_SampleReady && pend_v: begin
        src = SRC_PEND;
        load_word = pend_q;
      end
      !bus.i_SampleReady && !pend_v: begin
        src = SRC_LAST;
        load_word = last_q;
      end
    endcase
  end

  // One-deep pending buffer; any load empties it.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      pend_v <= 1'b0;
      pend_q <= '0;
    end else if (load) begin
      pend_v <= 1'b0;
    end else if (bus.i_SampleReady) begin
      pend_v <= 1'b1;
      pend_q <= bus.i_Sample;
    end
  end

  // Remember the word of the most recent frame.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      last_q <= '0;
    end else if (load) begin
      last_q <= load_word;
    end
  end

  // Frame shifter with one-bit I2S delay; right LSB
  // is parked in hold_q for the next slot 0.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      shreg  <= '0;
      sd_q   <= 1'b0;
      ws_q   <= 1'b0;
      hold_q <= 1'b0;
    end else if (fall) begin
      ws_q <= (next_slot >= SLOT_RIGHT);
      if (load) begin
        sd_q  <= hold_q;
        shreg <= {load_word, load_word};
      end else begin
        sd_q  <= shreg[FRAME_W-1];
        shreg <= shreg << 1;
      end
      if (next_slot == SLOT_LAST) begin
        hold_q <= shreg[FRAME_W-2];
      end
    end
  end

  assign bus.o_BitClock   = bit_clock;
  assign bus.o_WordSelect = ws_q;
  assign bus.o_SerialData = sd_q;
  assign bus.o_FrameStart = load;
  assign bus.o_Underrun   = load & (src == SRC_LAST);
  assign bus.o_Overrun    = bus.i_SampleReady & pend_v;

endmodule

// File: tb/tb_stage_sample_serializer.sv
// Bench for stage_sample_serializer with a
// sample-level reference model.
module tb_stage_sample_serializer;
  import stage_sample_serializer_pkg::*;

  logic i_Clock = 1'b0;
  logic i_Reset_n;

  stage_sample_serializer_if bus();

  stage_sample_serializer #(
    .BCLK_DIV (4)
  ) dut (
    .i_Clock   (i_Clock),
    .i_Reset_n (i_Reset_n),
    .bus       (bus)
  );

  always #5 i_Clock = ~i_Clock;

  int checks = 0;
  int failures = 0;
  int cyc;

  logic    m_pend_v;
  Sample_t m_pend;
  Sample_t m_last;
  Sample_t m_word;
  logic    m_hold;
  logic    m_k0;
  bit      m_in_frame;
  int      m_slot;
  logic    prev_bclk;
  logic    prev_ws;
  int      last_rise;
  int      last_ws_rise;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0;
    m_pend_v = 1'b0;
    m_pend = '0;
    m_last = '0;
    m_word = '0;
    m_hold = 1'b0;
    m_k0 = 1'b0;
    m_in_frame = 1'b0;
    m_slot = 0;
    prev_bclk = 1'b0;
    prev_ws = 1'b0;
    last_rise = -4;
    last_ws_rise = -128;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bclk"}, 32'(bus.o_BitClock), 0);
    chk({tag, "_ws"}, 32'(bus.o_WordSelect), 0);
    chk({tag, "_sd"}, 32'(bus.o_SerialData), 0);
    chk({tag, "_fs"}, 32'(bus.o_FrameStart), 0);
    chk({tag, "_ur"}, 32'(bus.o_Underrun), 0);
    chk({tag, "_ov"}, 32'(bus.o_Overrun), 0);
  endtask

  // One clock: drive at negedge, check flags,
  // advance model, then check BCLK/WS/SD.
  task automatic tick(input logic rdy,
                      input logic [15:0] smp);
    bit ld;
    logic exp_sd;
    Sample_t w;
    bus.i_SampleReady = rdy;
    bus.i_Sample = smp;
    #1;
    ld = ((cyc + 1) % 256 == 0);
    chk("frame_start", 32'(bus.o_FrameStart), 32'(ld));
    chk("underrun", 32'(bus.o_Underrun),
        32'(ld && !rdy && !m_pend_v));
    chk("overrun", 32'(bus.o_Overrun),
        32'(rdy && m_pend_v));
    if (ld) begin
      if (rdy) w = smp;
      else if (m_pend_v) w = m_pend;
      else w = m_last;
      m_pend_v = 1'b0;
      m_last = w;
      m_k0 = m_hold;
      m_hold = w[0];
      m_word = w;
      m_in_frame = 1'b1;
      m_slot = 0;
    end else if (rdy) begin
      m_pend = smp;
      m_pend_v = 1'b1;
    end
    @(posedge i_Clock);
    cyc++;
    @(negedge i_Clock);
    bus.i_SampleReady = 1'b0;
    if (!prev_bclk && bus.o_BitClock) begin
      chk("bclk_period", 32'(cyc - last_rise), 8);
      last_rise = cyc;
      if (m_in_frame && m_slot < 32) begin
        if (m_slot == 0) exp_sd = m_k0;
        else if (m_slot <= 16) exp_sd = m_word[16 - m_slot];
        else exp_sd = m_word[32 - m_slot];
        chk("sd", 32'(bus.o_SerialData), 32'(exp_sd));
        chk("ws", 32'(bus.o_WordSelect),
            32'(m_slot >= 16));
        m_slot++;
      end
    end
    if (!prev_ws && bus.o_WordSelect) begin
      chk("ws_period", 32'(cyc - last_ws_rise), 256);
      last_ws_rise = cyc;
    end
    prev_bclk = bus.o_BitClock;
    prev_ws = bus.o_WordSelect;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 16'h0);
  endtask

  task automatic run_to_load();
    while ((cyc + 1) % 256 != 0) tick(1'b0, 16'h0);
  endtask

  initial begin
    i_Reset_n = 1'b0;
    bus.i_Sample = '0;
    bus.i_SampleReady = 1'b0;
    model_reset();
    #1;
    chk_all_zero("reset");
    repeat (3) @(negedge i_Clock);
    i_Reset_n = 1'b1;
    model_reset();

    // 1/2: A5C3 before first load, then underrun repeat
    idle(40);
    tick(1'b1, 16'hA5C3);
    run_to_load();
    tick(1'b0, 16'h0);
    run_to_load();
    tick(1'b0, 16'h0);
    run_to_load();

    // 3: two mid-frame strobes, newest wins
    tick(1'b0, 16'h0);
    idle(30);
    tick(1'b1, 16'h1234);
    idle(20);
    tick(1'b1, 16'h8001);
    run_to_load();
    tick(1'b0, 16'h0);

    // 4: strobe in load cycle, empty then full pending
    run_to_load();
    tick(1'b1, 16'h7FFF);
    idle(50);
    tick(1'b1, 16'h0F0F);
    run_to_load();
    tick(1'b1, 16'h7FFF);

    // 5: phase-locked random stream
    for (int f = 0; f < 8; f++) begin
      run_to_load();
      tick(1'b1, 16'($urandom));
    end

    // random strobe timing
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 99) == 0,
           16'($urandom));
    end

    // 6: async reset in slot 10 with BCLK and SD high
    run_to_load();
    tick(1'b1, 16'hFFFF);
    while (cyc % 256 != 85) tick(1'b0, 16'h0);
    chk("pre_rst_bclk", 32'(bus.o_BitClock), 1);
    chk("pre_rst_sd", 32'(bus.o_SerialData), 1);
    #2;
    i_Reset_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    repeat (2) @(negedge i_Clock);
    i_Reset_n = 1'b1;
    model_reset();
    run_to_load();
    tick(1'b0, 16'h0);
    run_to_load();
    tick(1'b0, 16'h0);
    idle(40);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
